// File: rtl/wb_ram_pipe.sv
// ---------------------------------------------------------------------------
// wb_ram_pipe
//   Wishbone B4 pipelined RAM with byte-lane writes, a configurable read
//   latency of 1..4 cycles, stall signalling, out-of-range handling and an
//   optional zero-fill of the whole array after reset.
//
// Ports
//   clk_i        rising-edge clock for all logic
//   rst_i        asynchronous, active-high reset (RAM contents are kept)
//   cyc_i        bus cycle valid; low flushes every in-flight ack
//   stb_i        request strobe
//   we_i         1 = write, 0 = read
//   sel_i        byte-lane enables for writes
//   adr_i        word address
//   dat_i        write data
//   ack_o        one pulse per accepted request, READ_LATENCY cycles later
//   stall_o      1 = request not accepted this cycle (high while clearing)
//   dat_o        read data, valid with ack_o for reads, held otherwise
//   init_done_o  1 once the clear sequence has finished
// ---------------------------------------------------------------------------
module wb_ram_pipe #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 9,
    parameter int RAM_DEPTH      = 512,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic                    ack_o,
    output logic                    stall_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    init_done_o
);

    localparam int NSEL  = DATA_WIDTH / 8;
    localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAM_DEPTH + 1);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(RAM_DEPTH - 1);
    // One extra bit so RAM_DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_clr_cnt;
    logic                    r_stall;
    logic [DATA_WIDTH-1:0]   r_mem [0:RAM_DEPTH-1];

    logic [READ_LATENCY-1:0] r_vld_p;
    logic [READ_LATENCY-1:0] r_rd_p;
    logic [DATA_WIDTH-1:0]   r_dat_p [READ_LATENCY];

    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_wr_en;
    logic                    w_clr_we;
    logic [IDX_W-1:0]        w_idx;
    logic [IDX_W-1:0]        w_clr_idx;
    logic [DATA_WIDTH-1:0]   w_rdata;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NSEL-1:0]       lanes
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NSEL; b++) begin
            if (lanes[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    assign w_in_range = ({1'b0, adr_i} < DEPTH_A);
    // rst_i gating keeps the array untouched while reset is held.
    assign w_accept   = cyc_i & stb_i & ~r_stall & ~rst_i;
    assign w_idx      = adr_i[IDX_W-1:0];
    assign w_clr_idx  = r_clr_cnt[IDX_W-1:0];
    assign w_wr_en    = w_accept & we_i & w_in_range;
    assign w_clr_we   = (r_state == ST_CLEAR) & ~rst_i;
    assign w_rdata    = w_in_range ? r_mem[w_idx] : '0;

    // Clear sequencer: one zero word per cycle, then READY until next reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clr_cnt <= '0;
            if (CLEAR_ON_RESET != 0) begin
                r_state <= ST_CLEAR;
                r_stall <= 1'b1;
            end else begin
                r_state <= ST_READY;
                r_stall <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + CNT_W'(1);
                    if (r_clr_cnt == LAST_CNT) begin
                        r_state <= ST_READY;
                        r_stall <= 1'b0;
                    end
                end
                default: r_stall <= 1'b0;
            endcase
        end
    end

    // Storage: clear writes and bus writes never coincide (bus is stalled).
    always_ff @(posedge clk_i) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_idx] <= f_merge(r_mem[w_idx], dat_i, sel_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld_p <= '0;
            r_rd_p  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_dat_p[i] <= '0;
        end else begin
            // p0: acceptance edge, read word sampled here
            r_vld_p[0] <= w_accept;
            r_rd_p[0]  <= w_accept & ~we_i;
            if (w_accept & ~we_i) r_dat_p[0] <= w_rdata;
            // p1..pN: delay line; cyc_i low kills everything in flight and
            // data stages only move for reads so dat_o holds otherwise
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld_p[i] <= r_vld_p[i-1] & cyc_i;
                r_rd_p[i]  <= r_rd_p[i-1] & cyc_i;
                if (r_rd_p[i-1] & cyc_i) r_dat_p[i] <= r_dat_p[i-1];
            end
        end
    end

    assign ack_o       = r_vld_p[READ_LATENCY-1];
    assign dat_o       = r_dat_p[READ_LATENCY-1];
    assign stall_o     = r_stall;
    assign init_done_o = ~r_stall;

endmodule

// File: tb/tb_wb_ram_pipe.sv
module tb_wb_ram_pipe;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 512;
    localparam int LAT   = 3;

    logic          clk, rst, cyc, stb, we;
    logic [3:0]    sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w, dat_r;
    logic          ack, stall, init_done;

    wb_ram_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
        .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .sel_i(sel), .adr_i(adr), .dat_i(dat_w),
        .ack_o(ack), .stall_o(stall), .dat_o(dat_r), .init_done_o(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: memory image, edges since reset, pending responses.
    typedef struct {
        int          due;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic [31:0] mem_m [DEPTH];
    exp_t        pend_q[$];
    int          k;
    logic [31:0] exp_dat;

    typedef struct {
        bit          w;
        logic [3:0]  sel;
        logic [9:0]  adr;
        logic [31:0] dat;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One clock cycle: drive, let the edge happen, update model, check outputs.
    task automatic step(input bit c, input bit s, input bit w, input logic [3:0] sl,
                        input logic [9:0] a, input logic [31:0] d);
        bit   acc;
        exp_t e;
        cyc = c; stb = s; we = w; sel = sl; adr = a; dat_w = d;
        acc = c && s && (k >= DEPTH);
        @(posedge clk);
        k++;
        if (!c) pend_q.delete();
        if (acc) begin
            e.due  = k + LAT - 1;
            e.rd   = !w;
            e.data = (a < DEPTH) ? mem_m[a] : 32'h0;
            if (w && a < DEPTH) begin
                for (int b = 0; b < 4; b++)
                    if (sl[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
            end
            pend_q.push_back(e);
        end
        @(negedge clk);
        if (pend_q.size() > 0 && pend_q[0].due == k) begin
            if (pend_q[0].rd) exp_dat = pend_q[0].data;
            void'(pend_q.pop_front());
            chk($sformatf("ack@%0d", k), {31'b0, ack}, 32'd1);
        end else begin
            chk($sformatf("noack@%0d", k), {31'b0, ack}, 32'd0);
        end
        chk($sformatf("stall@%0d", k), {31'b0, stall}, {31'b0, (k < DEPTH)});
        chk($sformatf("init_done@%0d", k), {31'b0, init_done}, {31'b0, (k >= DEPTH)});
        chk($sformatf("dat_o@%0d", k), dat_r, exp_dat);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        #1;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd1);
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        chk("rst_dat_o", dat_r, 32'h0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        pend_q.delete();
        exp_dat = 32'h0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    endtask

    task automatic wait_clear(input string name);
        int cnt;
        cnt = stall ? 1 : 0;
        for (int i = 0; i < 600 && stall; i++) begin
            idle();
            if (stall) cnt++;
        end
        chk(name, cnt, DEPTH);
    endtask

    task automatic op_check(input vec_t v);
        int lat;
        step(1'b1, 1'b1, v.w, v.sel, v.adr, v.dat);
        lat = 1;
        while (!ack && lat < 10) begin
            idle();
            lat++;
        end
        chk({v.name, "_latency"}, lat, LAT);
        if (!v.w) chk({v.name, "_data"}, dat_r, v.exp);
    endtask

    function automatic vec_t mk(input bit w, input logic [3:0] sl, input logic [9:0] a,
                                input logic [31:0] d, input logic [31:0] e, input string n);
        vec_t v;
        v.w = w; v.sel = sl; v.adr = a; v.dat = d; v.exp = e; v.name = n;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vals [4];
        bit          ack_cap [7];
        logic [31:0] dat_cap [7];
        int          nack;

        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; dat_w = '0; k = 0; exp_dat = '0;
        @(negedge clk);
        do_reset(2);
        wait_clear("clear_len_first");

        // Fill some words, leave dat_o non-zero, reset while an ack is showing.
        step(1, 1, 1, 4'hF, 10'd0,   32'hA5A5A5A5);
        step(1, 1, 1, 4'hF, 10'd255, 32'hA5A5A5A5);
        step(1, 1, 1, 4'hF, 10'd511, 32'hA5A5A5A5);
        step(1, 1, 0, 4'h0, 10'd255, 32'h0);
        idle(); idle();
        chk("preload_readback", dat_r, 32'hA5A5A5A5);
        step(1, 1, 1, 4'hF, 10'd100, 32'hA5A5A5A5);
        step(1, 1, 1, 4'hF, 10'd101, 32'hA5A5A5A5);
        step(1, 1, 1, 4'hF, 10'd102, 32'hA5A5A5A5);
        do_reset(2);
        wait_clear("clear_len_after_preload");
        op_check(mk(0, 4'h0, 10'd0,   0, 32'h0, "clr_rd0"));
        op_check(mk(0, 4'h0, 10'd255, 0, 32'h0, "clr_rd255"));
        op_check(mk(0, 4'h0, 10'd511, 0, 32'h0, "clr_rd511"));

        // Directed vectors: byte lanes, range edges, sel=0.
        tbl.push_back(mk(1, 4'hF, 10'd5,    32'h11223344, 0, "w5_full"));
        tbl.push_back(mk(1, 4'h5, 10'd5,    32'hAABBCCDD, 0, "w5_lanes02"));
        tbl.push_back(mk(0, 4'h0, 10'd5,    0, 32'h11BB33DD, "r5_merged"));
        tbl.push_back(mk(1, 4'hF, 10'd88,   32'h12345678, 0, "w88"));
        tbl.push_back(mk(1, 4'hF, 10'd600,  32'h0000007E, 0, "w600_oor"));
        tbl.push_back(mk(0, 4'h0, 10'd600,  0, 32'h0, "r600_oor"));
        tbl.push_back(mk(0, 4'h0, 10'd88,   0, 32'h12345678, "r88_kept"));
        tbl.push_back(mk(1, 4'h0, 10'd7,    32'hFFFFFFFF, 0, "w7_sel0"));
        tbl.push_back(mk(0, 4'h0, 10'd7,    0, 32'h0, "r7_sel0"));
        tbl.push_back(mk(1, 4'hF, 10'd511,  32'hCAFEF00D, 0, "w511_last"));
        tbl.push_back(mk(1, 4'hF, 10'd512,  32'hDEADBEEF, 0, "w512_first_oor"));
        tbl.push_back(mk(0, 4'h0, 10'd512,  0, 32'h0, "r512_first_oor"));
        tbl.push_back(mk(0, 4'h0, 10'd511,  0, 32'hCAFEF00D, "r511_last"));
        tbl.push_back(mk(1, 4'hF, 10'd1023, 32'h01020304, 0, "w1023_top"));
        tbl.push_back(mk(0, 4'h0, 10'd1023, 0, 32'h0, "r1023_top"));
        tbl.push_back(mk(1, 4'h8, 10'd6,    32'hAB00FF00, 0, "w6_lane3"));
        tbl.push_back(mk(0, 4'h0, 10'd6,    0, 32'hAB000000, "r6_lane3"));
        foreach (tbl[i]) op_check(tbl[i]);

        // Back-to-back reads: four consecutive ack cycles, in order.
        vals[0] = 32'd10; vals[1] = 32'd20; vals[2] = 32'd30; vals[3] = 32'd40;
        for (int i = 0; i < 4; i++)
            op_check(mk(1, 4'hF, 10'(i + 1), vals[i], 0, "wseq"));
        for (int i = 0; i < 7; i++) begin
            if (i < 4) step(1, 1, 0, 4'h0, 10'(i + 1), 32'h0);
            else       idle();
            ack_cap[i] = ack;
            dat_cap[i] = dat_r;
        end
        for (int i = 0; i < 7; i++) begin
            bit want;
            want = (i >= LAT - 1) && (i <= LAT + 2);
            chk($sformatf("b2b_ack%0d", i), {31'b0, ack_cap[i]}, {31'b0, want});
            if (want) chk($sformatf("b2b_dat%0d", i), dat_cap[i], vals[i - (LAT - 1)]);
        end

        // Read immediately after a write to the same word.
        step(1, 1, 1, 4'hF, 10'd9, 32'h00000055);
        step(1, 1, 0, 4'h0, 10'd9, 32'h0);
        repeat (LAT - 1) idle();
        chk("raw_ack", {31'b0, ack}, 32'd1);
        chk("raw_dat", dat_r, 32'h00000055);
        idle();

        // Two reads in flight, then cyc_i drops: no ack for either.
        step(1, 1, 0, 4'h0, 10'd1, 32'h0);
        step(1, 1, 0, 4'h0, 10'd2, 32'h0);
        nack = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 4'h0, 10'd0, 32'h0);
            if (ack) nack++;
        end
        chk("flush_no_ack", nack, 0);
        op_check(mk(0, 4'h0, 10'd1, 0, 32'd10, "after_flush_rd1"));

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit          c, s, w;
            logic [9:0]  a;
            c = ($urandom % 8) != 0;
            s = ($urandom % 4) != 0;
            w = $urandom % 2;
            a = (($urandom % 4) == 0) ? 10'($urandom_range(500, 1023)) : 10'($urandom % 16);
            step(c, s, w, 4'($urandom), a, $urandom);
        end
        repeat (LAT + 2) idle();

        // Reset in the middle of the clear sequence restarts it from zero.
        op_check(mk(1, 4'hF, 10'd0, 32'h5A5A5A5A, 0, "w0_pre"));
        do_reset(2);
        repeat (200) idle();
        do_reset(3);
        wait_clear("clear_len_restart");
        op_check(mk(0, 4'h0, 10'd0, 0, 32'h0, "restart_rd0"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
